ahbl_sram_responder: RTL and testbench

//  AHB-Lite responder backed by a word-addressed synchronous memory, for formal and simulation benches.

---
 rtl/ahbl_sram_responder_pkg.sv | 26 ++
 rtl/ahbl_sram_responder_byte_mask.sv | 23 ++
 rtl/ahbl_sram_responder.sv | 166 ++++++++++++++++
 tb/tb_ahbl_sram_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_sram_responder_pkg.sv
// Shared AHB-Lite encodings and responder state encodings for the SRAM responder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ahbl_sram_responder_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      S_OKAY = 2'd0,
      S_WAIT = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } resp_state_t;

   // Number of byte-offset address bits for a bus of the given data width.
   function automatic int lane_bits(input int w_data);
      return $clog2(w_data / 8);
   endfunction

endpackage

// File: rtl/ahbl_sram_responder_byte_mask.sv
// Byte-lane mask for one transfer: lanes addr_lo .. addr_lo + (1 << size) - 1.
// Latency: combinational.
// Backpressure: none.
module ahbl_sram_responder_byte_mask #(
   parameter int W_DATA = 32,
   parameter int W_LO   = 2
) (
   input  logic [2:0]          size,
   input  logic [W_LO-1:0]     addr_lo,
   output logic [W_DATA/8-1:0] mask
);

   // Lanes are only ever asked for aligned, in-width transfers, so a plain range test suffices.
   always_comb begin
      mask = '0;
      for (int i = 0; i < W_DATA / 8; i++) begin
         if ((i >= int'(addr_lo)) && (i < int'(addr_lo) + (1 << size))) begin
            mask[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite responder over a word-addressed synchronous memory; optional stalls under HAZARD3_AHBL_SRAM_WAIT_EN.
// Latency: zero-wait OKAY (WAIT_CYCLES stalls per active data phase when enabled), two-cycle ERROR.
// Backpressure: stalls only through src_hready_resp; address phases are sampled only while src_hready is high.
module ahbl_sram_responder
   import ahbl_sram_responder_pkg::*;
#(
   parameter int W_ADDR      = 32,
   parameter int W_DATA      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              src_hready,
   output logic              src_hready_resp,
   output logic              src_hresp,
   input  logic [W_ADDR-1:0] src_haddr,
   input  logic              src_hwrite,
   input  logic [1:0]        src_htrans,
   input  logic [2:0]        src_hsize,
   input  logic [2:0]        src_hburst,
   input  logic [3:0]        src_hprot,
   input  logic              src_hmastlock,
   input  logic [W_DATA-1:0] src_hwdata,
   output logic [W_DATA-1:0] src_hrdata
);

   localparam int NB    = W_DATA / 8;
   localparam int LB    = lane_bits(W_DATA);
   localparam int LD    = $clog2(DEPTH);
   localparam int W_IDX = LB + LD;
   localparam logic [W_ADDR:0] MEM_BYTES = (W_ADDR + 1)'(DEPTH * NB);

`ifdef HAZARD3_AHBL_SRAM_WAIT_EN
   localparam bit WAIT_ON = (WAIT_CYCLES > 0);
   localparam int W_CNT   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   logic [W_CNT-1:0] wait_cnt, wait_cnt_nxt;
`else
   localparam int UNUSED_WAIT_CYCLES = WAIT_CYCLES;
`endif

   resp_state_t       state, state_nxt;
   logic              accept, addr_err, rd_sample, wr_commit;
   logic [W_ADDR-1:0] align_mask;
   logic              dph_act, dph_write;
   logic [2:0]        dph_size;
   logic [W_IDX-1:0]  dph_addr;
   logic [NB-1:0]     wmask;
   logic [LD-1:0]     widx, ridx;
   logic [W_DATA-1:0] rd_word;
   logic [W_DATA-1:0] mem [DEPTH];
   logic              unused_ok;

   assign unused_ok = ^{src_hburst, src_hprot, src_hmastlock};

   assign accept    = src_hready && ((src_htrans == HTRANS_NSEQ) || (src_htrans == HTRANS_SEQ));
   assign rd_sample = accept && !addr_err && !src_hwrite;
   assign wr_commit = src_hready_resp && dph_act && dph_write;
   assign widx      = dph_addr[LB +: LD];
   assign ridx      = src_haddr[LB +: LD];

   assign src_hready_resp = (state == S_OKAY) || (state == S_ERR2);
   assign src_hresp       = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

   ahbl_sram_responder_byte_mask #(
      .W_DATA (W_DATA),
      .W_LO   (LB)
   ) u_byte_mask (
      .size    (dph_size),
      .addr_lo (dph_addr[LB-1:0]),
      .mask    (wmask)
   );

   // Classify the address phase: out of range, misaligned, or wider than the bus.
   always_comb begin
      align_mask = (W_ADDR'(1) << src_hsize) - W_ADDR'(1);
      addr_err   = ({1'b0, src_haddr} >= MEM_BYTES)
                || ((src_haddr & align_mask) != '0)
                || ((32'd8 << src_hsize) > W_DATA);
   end

   // Read data with same-word forwarding from the write completing on this edge.
   always_comb begin
      rd_word = mem[ridx];
      for (int i = 0; i < NB; i++) begin
         if (wr_commit && (widx == ridx) && wmask[i]) begin
            rd_word[i*8 +: 8] = src_hwdata[i*8 +: 8];
         end
      end
   end

   // Response sequencing: ERR1 -> ERR2 is fixed; OKAY and ERR2 both accept the next transfer.
   always_comb begin
      state_nxt = state;
`ifdef HAZARD3_AHBL_SRAM_WAIT_EN
      wait_cnt_nxt = wait_cnt;
`endif
      case (state)
         S_OKAY, S_ERR2: begin
            if (accept && addr_err) begin
               state_nxt = S_ERR1;
`ifdef HAZARD3_AHBL_SRAM_WAIT_EN
            end else if (WAIT_ON && accept) begin
               state_nxt    = S_WAIT;
               wait_cnt_nxt = W_CNT'(WAIT_CYCLES - 1);
`endif
            end else begin
               state_nxt = S_OKAY;
            end
         end
         S_WAIT: begin
`ifdef HAZARD3_AHBL_SRAM_WAIT_EN
            if (wait_cnt == '0) begin
               state_nxt = S_OKAY;
            end else begin
               wait_cnt_nxt = wait_cnt - 1'b1;
            end
`else
            state_nxt = S_OKAY;
`endif
         end
         S_ERR1: state_nxt = S_ERR2;
      endcase
   end

   // State, data phase flags and registered read data; reset abandons any phase in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_OKAY;
         dph_act    <= 1'b0;
         dph_write  <= 1'b0;
         dph_size   <= '0;
         dph_addr   <= '0;
         src_hrdata <= '0;
`ifdef HAZARD3_AHBL_SRAM_WAIT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         state <= state_nxt;
`ifdef HAZARD3_AHBL_SRAM_WAIT_EN
         wait_cnt <= wait_cnt_nxt;
`endif
         if (src_hready) begin
            dph_act   <= accept && !addr_err;
            dph_write <= src_hwrite;
            dph_size  <= src_hsize;
            dph_addr  <= src_haddr[W_IDX-1:0];
         end
         if (rd_sample) begin
            src_hrdata <= rd_word;
         end
      end
   end

   // Memory has no reset; a write is committed only on its completing cycle outside reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_commit) begin
         for (int i = 0; i < NB; i++) begin
            if (wmask[i]) begin
               mem[widx][i*8 +: 8] <= src_hwdata[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Self-checking bench: single-master pipelined AHB-Lite traffic against a transaction-level byte memory model.
// Latency: model expects zero-wait OKAY (or WAIT_CYCLES stalls with HAZARD3_AHBL_SRAM_WAIT_EN), two-cycle ERROR.
// Backpressure: src_hready is looped back from src_hready_resp (single slave on the bus).
module tb_ahbl_sram_responder;
   import ahbl_sram_responder_pkg::*;

   localparam int W_ADDR      = 32;
   localparam int W_DATA      = 32;
   localparam int DEPTH       = 1024;
   localparam int WAIT_CYCLES = 2;
   localparam int MEM_BYTES   = DEPTH * W_DATA / 8;
`ifdef HAZARD3_AHBL_SRAM_WAIT_EN
   localparam int MODEL_WAIT = WAIT_CYCLES;
`else
   localparam int MODEL_WAIT = 0;
`endif

   logic              clk, rst_n, src_hready, src_hready_resp, src_hresp;
   logic [W_ADDR-1:0] src_haddr;
   logic              src_hwrite, src_hmastlock;
   logic [1:0]        src_htrans;
   logic [2:0]        src_hsize, src_hburst;
   logic [3:0]        src_hprot;
   logic [W_DATA-1:0] src_hwdata, src_hrdata;

   assign src_hready = src_hready_resp;

   ahbl_sram_responder #(
      .W_ADDR(W_ADDR), .W_DATA(W_DATA), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .src_hready(src_hready), .src_hready_resp(src_hready_resp),
      .src_hresp(src_hresp), .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
      .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
      .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      logic [1:0]  trans;
      bit          write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          lit_en;
      logic [31:0] lit_val;
   } xfer_t;

   xfer_t       q[$];
   logic [7:0]  memb [MEM_BYTES];
   bit          chk_en, lit_en;
   logic        exp_ready, exp_resp;
   logic [31:0] exp_rdata, lit_val;
   int          n_cmp, n_bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every checked cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("hready_resp", 32'(src_hready_resp), 32'(exp_ready));
         chk("hresp", 32'(src_hresp), 32'(exp_resp));
         chk("hrdata", src_hrdata, exp_rdata);
         if (lit_en) chk("hrdata_literal", src_hrdata, lit_val);
      end
   end

   function automatic xfer_t mk(input logic [1:0] tr, input bit wr, input logic [31:0] a,
                                input logic [2:0] sz, input logic [31:0] d);
      xfer_t x;
      x = '{default: '0};
      x.trans = tr; x.write = wr; x.addr = a; x.size = sz; x.wdata = d;
      return x;
   endfunction

   function automatic xfer_t rd_lit(input logic [31:0] a, input logic [31:0] v);
      xfer_t x;
      x = mk(HTRANS_NSEQ, 1'b0, a, 3'd2, 32'h0);
      x.lit_en = 1'b1; x.lit_val = v;
      return x;
   endfunction

   function automatic xfer_t rst_marker();
      xfer_t x;
      x = mk(HTRANS_IDLE, 1'b0, 32'h0, 3'd0, 32'h0);
      x.rst = 1'b1;
      return x;
   endfunction

   function automatic xfer_t pop_or_idle();
      if (q.size() > 0) return q.pop_front();
      return mk(HTRANS_IDLE, 1'b0, 32'h0, 3'd0, 32'h0);
   endfunction

   // Error rule from the bus contract: out of range, misaligned, or wider than the bus.
   function automatic bit is_err(input xfer_t x);
      return (x.addr >= MEM_BYTES) || ((x.addr % (32'd1 << x.size)) != 0) || ((8 << x.size) > W_DATA);
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] w;
      int base;
      base = int'(a) & ~3;
      for (int k = 0; k < 4; k++) w[k*8 +: 8] = memb[base + k];
      return w;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      for (int b = 0; b < (1 << sz); b++) begin
         int x;
         x = int'(a) + b;
         memb[x] = d[(x % 4) * 8 +: 8];
      end
   endtask

   function automatic xfer_t rand_xfer();
      xfer_t x;
      int r, k;
      logic [2:0] sz;
      r = $urandom_range(0, 99);
      if (r < 2) return rst_marker();
      k = $urandom_range(0, 9);
      sz = (k < 3) ? 3'd0 : (k < 6) ? 3'd1 : (k < 9) ? 3'd2 : 3'd3;
      x = mk(HTRANS_NSEQ, 1'($urandom_range(0, 1)), 32'h0, sz, $urandom);
      k = $urandom_range(0, 9);
      x.trans = (k == 0) ? HTRANS_IDLE : (k == 1) ? HTRANS_BUSY : (k < 6) ? HTRANS_NSEQ : HTRANS_SEQ;
      k = $urandom_range(0, 19);
      if (k == 0)      x.addr = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      else if (k == 1) x.addr = 32'($urandom_range(0, 255));
      else             x.addr = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 1);
      return x;
   endfunction

   initial begin : master
      xfer_t       ap;
      int          dph_kind, dph_cnt, cyc;
      bit          dph_write, dph_lit_en, post_rst;
      logic [31:0] dph_addr, dph_wdata, dph_lit_val;
      logic [2:0]  dph_size;

      n_cmp = 0; n_bad = 0; chk_en = 1'b0; lit_en = 1'b0; lit_val = '0;
      exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = '0;
      rst_n = 1'b0; src_htrans = HTRANS_IDLE; src_haddr = '0; src_hwrite = 1'b0; src_hsize = '0;
      src_hburst = '0; src_hprot = '0; src_hmastlock = 1'b0; src_hwdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 64; i++)
         q.push_back(mk(HTRANS_NSEQ, 1'b1, 32'(i * 4), 3'd2,
                        (i == 0) ? 32'hCAFEF00D : (i == 20) ? 32'h50505050 : $urandom));
      q.push_back(mk(HTRANS_NSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
      q.push_back(rd_lit(32'h10, 32'hDEADBEEF));
      q.push_back(mk(HTRANS_NSEQ, 1'b1, 32'h20, 3'd2, 32'h11223344));
      q.push_back(mk(HTRANS_NSEQ, 1'b1, 32'h21, 3'd0, 32'h0000AA00));
      q.push_back(rd_lit(32'h20, 32'h1122AA44));
      q.push_back(mk(HTRANS_NSEQ, 1'b0, 32'h1000, 3'd2, 32'h0));
      q.push_back(rd_lit(32'h0, 32'hCAFEF00D));
      q.push_back(mk(HTRANS_NSEQ, 1'b1, 32'h3, 3'd1, 32'hFFFFFFFF));
      q.push_back(rd_lit(32'h0, 32'hCAFEF00D));
      q.push_back(mk(HTRANS_NSEQ, 1'b0, 32'h40, 3'd2, 32'h0));
      q.push_back(mk(HTRANS_IDLE, 1'b0, 32'h0, 3'd0, 32'h0));
      q.push_back(mk(HTRANS_NSEQ, 1'b1, 32'h50, 3'd2, 32'hFFFFFFFF));
      q.push_back(rst_marker());
      q.push_back(rd_lit(32'h50, 32'h50505050));
      q.push_back(mk(HTRANS_NSEQ, 1'b1, 32'hFFC, 3'd2, 32'h0BADF00D));
      q.push_back(rd_lit(32'hFFC, 32'h0BADF00D));
      q.push_back(mk(HTRANS_NSEQ, 1'b0, 32'h1000, 3'd2, 32'h0));
      q.push_back(mk(HTRANS_SEQ, 1'b0, 32'hFFFFFFFC, 3'd2, 32'h0));
      q.push_back(mk(HTRANS_NSEQ, 1'b0, 32'h8, 3'd3, 32'h0));
      for (int i = 0; i < 400; i++) q.push_back(rand_xfer());

      dph_kind = 0; dph_cnt = 0; dph_write = 1'b0; dph_addr = '0; dph_size = '0;
      dph_wdata = '0; dph_lit_en = 1'b0; dph_lit_val = '0; post_rst = 1'b1; cyc = 0;
      ap = pop_or_idle();

      while ((q.size() > 0 || ap.trans[1] || ap.rst || dph_kind != 0) && cyc < 20000) begin
         if (ap.rst) begin
            rst_n = 1'b0;
            src_htrans = HTRANS_IDLE; src_haddr = $urandom; src_hwrite = 1'b0; src_hsize = '0;
         end else begin
            src_htrans = ap.trans; src_haddr = ap.addr; src_hwrite = ap.write; src_hsize = ap.size;
         end
         src_hwdata = (dph_kind == 1 && dph_write) ? dph_wdata : $urandom;
         src_hburst = 3'($urandom); src_hprot = 4'($urandom); src_hmastlock = 1'($urandom);

         case (dph_kind)
            1:       begin exp_ready = (dph_cnt >= MODEL_WAIT); exp_resp = 1'b0; end
            2:       begin exp_ready = (dph_cnt >= 1);          exp_resp = 1'b1; end
            default: begin exp_ready = 1'b1;                    exp_resp = 1'b0; end
         endcase
         lit_en  = post_rst || ((dph_kind == 1) && !dph_write && dph_lit_en && exp_ready);
         lit_val = post_rst ? 32'h0 : dph_lit_val;
         post_rst = 1'b0;
         chk_en = 1'b1;

         @(posedge clk);
         #1;
         cyc++;
         if (ap.rst) begin
            rst_n = 1'b1;
            dph_kind = 0; dph_cnt = 0; exp_rdata = '0; post_rst = 1'b1;
            ap = pop_or_idle();
         end else if (exp_ready) begin
            if (dph_kind == 1 && dph_write) model_write(dph_addr, dph_size, dph_wdata);
            dph_kind = !ap.trans[1] ? 0 : is_err(ap) ? 2 : 1;
            dph_cnt = 0; dph_write = ap.write; dph_addr = ap.addr; dph_size = ap.size;
            dph_wdata = ap.wdata; dph_lit_en = ap.lit_en; dph_lit_val = ap.lit_val;
            if (dph_kind == 1 && !ap.write) exp_rdata = model_word(ap.addr);
            ap = pop_or_idle();
         end else begin
            dph_cnt++;
         end
      end

      if (cyc >= 20000) begin
         n_cmp++; n_bad++;
         $display("FAIL cycle_budget: ran %0d cycles, expected fewer than 20000", cyc);
      end

      src_htrans = HTRANS_IDLE;
      exp_ready = 1'b1; exp_resp = 1'b0; lit_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
